// File: rtl/pipe_pkg.sv
// Shared types for the sample packer: geometry, packed output word, FSM states.
package pipe_pkg;
  localparam int DATA_W = 6;
  localparam int GROUP  = 4;
  localparam int CNT_W  = $clog2(GROUP) + 1;

  typedef struct packed {
    logic [DATA_W*GROUP-1:0] data;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              sum;
  } packed_word_t;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_FLUSH_WAIT
  } pk_state_e;
endpackage

// File: rtl/pipe_fifo.sv
// Small synchronous FIFO of packed words. Push while full is honoured only
// when a pop happens on the same edge; head reads as zero while empty.
module pipe_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  packed_word_t wdata_i,
  input  logic         pop_i,
  output packed_word_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  packed_word_t mem [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem[rd_q[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/sample_packer.sv
// Packs GROUP samples into one word with count and 8-bit checksum, queued in
// a small FIFO. A flush emits the partial word, waiting for FIFO space if needed.
module sample_packer
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int GROUP  = pipe_pkg::GROUP,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*GROUP-1:0]  out_data,
  output logic [$clog2(GROUP):0]   out_cnt,
  output logic [7:0]               out_sum,
  output logic [15:0]              words_sent
);
  localparam int CW = $clog2(GROUP) + 1;

  pk_state_e               state_q, state_d;
  logic [CW-1:0]           fill_q, fill_d, fill_acc;
  logic [DATA_W*GROUP-1:0] shreg_q, shreg_d, data_acc;
  logic [7:0]              sum_q, sum_d, sum_acc;
  logic [15:0]             words_q;
  logic                    accept, pop, push, space, full, empty, flush_pend;
  packed_word_t            push_w, head_w;

  assign flush_pend = (state_q == PK_FLUSH_WAIT);
  // Registered state only: a same-cycle pop never opens in_ready.
  assign in_ready   = !flush_pend && (fill_q != CW'(GROUP-1) || !full);
  assign accept     = in_valid && in_ready;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign space      = !full || pop;

  // Next-state: accumulate the accepted sample, then decide full/flush push.
  always_comb begin
    fill_acc = fill_q;
    data_acc = shreg_q;
    sum_acc  = sum_q;
    if (accept) begin
      fill_acc = fill_q + 1'b1;
      data_acc[fill_q*DATA_W +: DATA_W] = in_data;
      sum_acc  = sum_q + 8'(in_data);
    end
    fill_d  = fill_acc;
    shreg_d = data_acc;
    sum_d   = sum_acc;
    push    = 1'b0;
    push_w  = '{data: data_acc, cnt: fill_acc, sum: sum_acc};
    state_d = state_q;
    if (accept && fill_q == CW'(GROUP-1)) begin
      // Completed word; a coincident flush has nothing left to emit.
      push    = 1'b1;
      fill_d  = '0;
      shreg_d = '0;
      sum_d   = '0;
    end else if ((flush || flush_pend) && fill_acc != '0) begin
      if (space) begin
        push    = 1'b1;
        fill_d  = '0;
        shreg_d = '0;
        sum_d   = '0;
      end
    end
    if ((flush || flush_pend) && fill_acc != '0 && !push) state_d = PK_FLUSH_WAIT;
    else if (fill_d != '0)                                  state_d = PK_FILL;
    else                                                    state_d = PK_IDLE;
  end

  // Packer state, partial word and handshake counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PK_IDLE;
      fill_q  <= '0;
      shreg_q <= '0;
      sum_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      shreg_q <= shreg_d;
      sum_q   <= sum_d;
      if (pop && words_q != 16'hFFFF) words_q <= words_q + 1'b1;
    end
  end

  pipe_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (push_w),
    .pop_i   (pop),
    .rdata_o (head_w),
    .full_o  (full),
    .empty_o (empty)
  );

  assign out_data   = head_w.data;
  assign out_cnt    = head_w.cnt;
  assign out_sum    = head_w.sum;
  assign words_sent = words_q;
endmodule

// File: tb/tb_sample_packer.sv
module tb_sample_packer;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 0;
  logic [5:0]  in_data = '0;
  logic [23:0] out_data;
  logic [2:0]  out_cnt;
  logic [7:0]  out_sum;
  logic [15:0] words_sent, ws0;

  int n_chk = 0, n_err = 0, popped = 0;

  typedef struct { logic [23:0] data; logic [2:0] cnt; logic [7:0] sum; } exp_t;
  exp_t       mq[$];
  logic [5:0] cur[$];

  sample_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_cnt(out_cnt), .out_sum(out_sum), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Close the current sample list into an expected word.
  task automatic emit();
    exp_t e;
    e.data = '0; e.sum = '0;
    for (int i = 0; i < cur.size(); i++) begin
      e.data = e.data | (24'(cur[i]) << (6*i));
      e.sum  = e.sum + 8'(cur[i]);
    end
    e.cnt = 3'(cur.size());
    mq.push_back(e);
    cur.delete();
  endtask

  // Reference model: words are whatever was handed over, grouped by fours or
  // cut short by a flush; every output handshake must match the oldest one.
  always @(negedge clk) begin
    if (rst) begin
      mq.delete(); cur.delete(); popped = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (mq.size() == 0) chk("spurious_word", 1, 0);
        else begin
          exp_t e;
          e = mq.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_cnt",  out_cnt,  e.cnt);
          chk("sb_sum",  out_sum,  e.sum);
        end
        popped++;
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        if (cur.size() == 4) emit();
      end
      if (flush && cur.size() > 0) emit();
    end
  end

  task automatic send(input logic [5:0] d, input logic fl);
    int n = 0;
    in_valid = 1; in_data = d; flush = fl;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
  endtask

  task automatic pulse_flush();
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", out_valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    @(posedge clk); #1;

    // First word and its one-cycle latency.
    out_ready = 1;
    send(6'h01, 0); send(6'h02, 0); send(6'h03, 0); send(6'h04, 0);
    chk("w1_valid", out_valid, 1);
    chk("w1_data", out_data, 24'h103081);
    chk("w1_cnt", out_cnt, 4);
    chk("w1_sum", out_sum, 8'h0A);
    @(posedge clk); #1;
    chk("w1_words", words_sent, 1);
    chk("w1_gone", out_valid, 0);

    // Backpressure: two words queued, third word stalls at its last sample.
    out_ready = 0;
    for (int i = 0; i < 11; i++) send(6'(i + 5), 0);
    chk("bp_in_ready", in_ready, 0);
    in_valid = 1; in_data = 6'd16;
    @(negedge clk);
    chk("bp_in_ready_hold", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1;
    send(6'd16, 0);
    drain();
    chk("bp_ready_after", in_ready, 1);

    // Partial word via flush.
    send(6'h3F, 0); send(6'h3F, 0);
    pulse_flush();
    chk("fl_data", out_data, 24'h000FFF);
    chk("fl_cnt", out_cnt, 2);
    chk("fl_sum", out_sum, 8'h7E);
    @(posedge clk); #1;

    // Flush with a full FIFO waits for space.
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(6'(i * 7), 0);
    send(6'h15, 0);
    pulse_flush();
    chk("pend_in_ready", in_ready, 0);
    chk("pend_head_cnt", out_cnt, 4);
    out_ready = 1;
    drain();
    chk("pend_ready_after", in_ready, 1);

    // Flush with nothing collected, then flush coinciding with a full word.
    ws0 = words_sent;
    pulse_flush();
    repeat (3) @(posedge clk); #1;
    chk("empty_flush_valid", out_valid, 0);
    chk("empty_flush_words", words_sent, ws0);
    send(6'h11, 0); send(6'h22, 0); send(6'h33, 0); send(6'h2A, 1);
    drain();
    chk("full_flush_words", words_sent, 16'(ws0 + 1));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 6'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clk); #1;
    if (in_ready && !out_valid) begin
      pulse_flush();
      drain();
    end
    drain();
    chk("rand_words", words_sent, 16'(popped));

    // Reset mid-word with a queued word.
    out_ready = 0;
    send(6'h01, 0); send(6'h02, 0); send(6'h03, 0); send(6'h04, 0);
    send(6'h05, 0); send(6'h06, 0);
    rst = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_cnt", out_cnt, 0);
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_words", words_sent, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    send(6'd10, 0); send(6'd11, 0); send(6'd12, 0); send(6'd13, 0);
    chk("post_rst_data", out_data, 24'h34C2CA);
    chk("post_rst_sum", out_sum, 8'd46);
    drain();
    chk("post_rst_words", words_sent, 1);

    // One-sample flushed words every cycle to reach saturation.
    in_valid = 1; flush = 1; out_ready = 1;
    for (int c = 0; c < 65540; c++) begin
      in_data = 6'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 0; flush = 0;
    drain();
    chk("sat_words", words_sent, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat_hold", words_sent, 16'hFFFF);
    chk("sb_leftover", mq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
